// File: rtl/sys_timing_pkg.sv
// Shared C64 timing constants and types for the clk32 domain.
package sys_timing_pkg;

  // One phi0 period spans this many clk32 cycles.
  localparam int unsigned PHI_PHASES = 32;
  // The dot clock runs at clk32 / DOT_DIV.
  localparam int unsigned DOT_DIV    = 4;
  localparam int unsigned PHASE_W    = $clog2(PHI_PHASES);
  localparam int unsigned DOT_W      = $clog2(DOT_DIV);

  localparam logic [PHASE_W-1:0] PHI2_RISE_PHASE = PHASE_W'(15);
  localparam logic [PHASE_W-1:0] CYCLE_END_PHASE = PHASE_W'(31);
  localparam logic [DOT_W-1:0]   DOT_LAST        = DOT_W'(DOT_DIV - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StRun      = 2'd2
  } state_e;

  // One counter serves both the lock filter and the hold period, so size it for the larger.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sys_timing_if.sv
// Timing bundle broadcast from sys_timing to every VIC-II / CPU-bus consumer.
interface sys_timing_if;
  import sys_timing_pkg::*;

  logic               sys_rstn;
  logic               running;
  logic [PHASE_W-1:0] phase;
  logic               dot_ce;
  logic               phi2;
  logic               phi2_rise_ce;
  logic               cycle_end_ce;

  modport master (
    output sys_rstn,
    output running,
    output phase,
    output dot_ce,
    output phi2,
    output phi2_rise_ce,
    output cycle_end_ce
  );

  modport slave (
    input sys_rstn,
    input running,
    input phase,
    input dot_ce,
    input phi2,
    input phi2_rise_ce,
    input cycle_end_ce
  );

endinterface

// File: rtl/sys_timing_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Each bit is synchronized independently; only use WIDTH > 1 for unrelated level signals.
module sys_timing_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sys_timing.sv
// System reset sequencer and C64 timing-enable generator (clk32 domain).
// Filters the PLL lock, holds sys_rstn low for a fixed period, then runs the phi0 phase
// counter and decodes the dot-clock and phi2 enables from it.
module sys_timing
  import sys_timing_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic           clk32,
  input  logic           resetn,
  input  logic           pll_lock,
  sys_timing_if.master   tim
);

  localparam int unsigned     CNT_W     = cnt_width(LOCK_FILTER, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic               lock_s;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               rstn_q, rstn_d;

  // pll_lock is asynchronous; nothing else in this block looks at it directly.
  sys_timing_sync2 #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (clk32),
    .rstn (resetn),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // Next state and shared counter; lock loss overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!lock_s) begin
      state_d = StWaitLock;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (cnt_q == FILT_LAST) begin
            state_d = StHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Phase and reset follow state_d so the first RUN cycle already shows phase 0 and
  // sys_rstn high, and leaving RUN zeroes both in the same cycle.
  always_comb begin
    phase_d = '0;
    rstn_d  = (state_d == StRun);
    if ((state_q == StRun) && (state_d == StRun)) begin
      phase_d = phase_q + 1'b1;
    end
  end

  // State, counter, phase and reset registers.
  always_ff @(posedge clk32 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      phase_q <= '0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rstn_q  <= rstn_d;
    end
  end

  // Enable decodes from the registered phase, all gated by running.
  always_comb begin
    tim.sys_rstn     = rstn_q;
    tim.running      = rstn_q;
    tim.phase        = phase_q;
    tim.dot_ce       = rstn_q & (phase_q[DOT_W-1:0] == DOT_LAST);
    tim.phi2         = rstn_q & phase_q[PHASE_W-1];
    tim.phi2_rise_ce = rstn_q & (phase_q == PHI2_RISE_PHASE);
    tim.cycle_end_ce = rstn_q & (phase_q == CYCLE_END_PHASE);
  end

endmodule

// File: doc/sys_timing.md
Name: sys_timing

Overview:
- Downstream of the clock generator, in the clk32 domain.
- Turns the raw PLL lock indication into a clean, filtered, synchronously-deasserted system reset.
- Once running, generates the C64 timing enables for the core:
  - 8 MHz dot-clock enable (every 4th clk32)
  - 1 MHz phi0 phase counter, phi2 level, and phi edge strobes (32 clk32 cycles per phi0 cycle)
- Every VIC-II/CPU-bus block in the design consumes these enables instead of deriving its own.

Parameters:
LOCK_FILTER, 16, consecutive synchronized-lock-high cycles required before leaving WAIT_LOCK (>=1)
HOLD_CYCLES, 1024, cycles sys_rstn is held low after lock is accepted (>=1)

Ports:
clk32  input  1  32 MHz system clock, sole clock
resetn  input  1  asynchronous active-low reset
pll_lock  input  1  lock from clock generator, asynchronous to clk32
sys_rstn  output  1  registered system reset, active-low, deasserts synchronously to clk32
running  output  1  high in RUN state
phase  output  5  phi0 phase 0..31, 0 when not running
dot_ce  output  1  dot-clock enable, one clk32 pulse per 4 cycles
phi2  output  1  phi2 level (phase >= 16)
phi2_rise_ce  output  1  single-cycle strobe at phase == 15
cycle_end_ce  output  1  single-cycle strobe at phase == 31 (last cycle of phi0 period)

Behaviour:
- Reset: resetn low asynchronously clears everything.
  - sync FFs = 0, state = WAIT_LOCK, counters = 0.
  - All outputs low: sys_rstn=0, running=0, phase=0, dot_ce=0, phi2=0, both strobes 0.
- Lock synchronizer: pll_lock passes through a 2-FF synchronizer → lock_s. No other logic samples pll_lock directly.
- State machine (registered): WAIT_LOCK, HOLD, RUN.
  - WAIT_LOCK:
    - filt counter increments while lock_s=1; clears to 0 on any lock_s=0.
    - When the counter reaches LOCK_FILTER-1 with lock_s=1: go to HOLD, clear the counter.
  - HOLD:
    - Counter increments each cycle.
    - At HOLD_CYCLES-1: go to RUN.
  - RUN: stays until lock_s=0.
  - Any state with lock_s=0: next state WAIT_LOCK, counters cleared.
    - Lock-loss priority beats every other transition, including the HOLD→RUN transition in the same cycle.
- Counter widths: $clog2 of the larger of LOCK_FILTER and HOLD_CYCLES, plus 1. One shared counter is used for both states. No wrap in normal operation.
- sys_rstn = registered (state==RUN). running equals sys_rstn.
  - Latency: with pll_lock held high from a clean reset, sys_rstn rises exactly 2 + LOCK_FILTER + HOLD_CYCLES clk32 rising edges after the first edge sampling pll_lock=1, ±1 for synchronizer metastability alignment.
  - The bench uses pll_lock changes aligned to the falling edge so the count is exact.
- Lock loss in RUN:
  - sys_rstn falls 3 edges after pll_lock falls (2 sync + 1 state).
  - phase and all enables are 0 in that same cycle.
- Phase counter:
  - Held at 0 unless the state is RUN.
  - In RUN it increments every cycle with 5-bit wrap, 31→0.
  - The first RUN cycle shows phase=0, aligned to the sys_rstn rising edge.
- Enable decodes: combinational from the registered phase, gated by running. All enables are 0 outside RUN.
  - dot_ce = running & (phase[1:0]==3)
  - phi2 = running & phase[4]
  - phi2_rise_ce = running & (phase==15)
  - cycle_end_ce = running & (phase==31)
- Per 32-cycle period: exactly 8 dot_ce pulses, 16 phi2-high cycles, 1 pulse of each strobe.
- Re-lock after loss repeats the full filter + hold sequence. Phase restarts at 0.

Decomposition:
- Shared timing package:
  - PHI_PHASES=32, DOT_DIV=4
  - PHI2_RISE_PHASE=15, CYCLE_END_PHASE=31
  - state enum {WAIT_LOCK, HOLD, RUN}
- One natural sub-module: sync2, a generic 2-FF synchronizer with async active-low reset. It is reused by other CDC points.

Test Plan:
- Clean start, LOCK_FILTER=4, HOLD_CYCLES=8, pll_lock high from cycle 0 → sys_rstn=0 through edge 13, rises at edge 14; phase=0 on that cycle, 1 next.
- Glitchy lock: pll_lock high 3 cycles, low 1, then high → filter restarts; sys_rstn rises 14 edges after the final rise. No early release.
- Steady RUN for 64 cycles → dot_ce pulses at phases 3,7,...,31 (16 total), phi2 high at phases 16..31, phi2_rise_ce only at phase 15, cycle_end_ce only at phase 31, phase wraps 31→0.
- Lock drop in RUN at phase 20 → 3 edges later sys_rstn=0, phase=0, all enables 0. Re-assert → full 14-edge sequence, phase restarts at 0.
- Lock drop during HOLD (counter=5) → back to WAIT_LOCK, sys_rstn stays 0, counter cleared.
- Async resetn pulse mid-RUN (between clock edges) → all outputs 0 immediately. Release with lock high → full sequence again.
